multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I datapath. Decodes op/funct3/funct7b5 into datapath strobes and the 3-bit ALU control word, and consumes the ALU Zero flag for branch resolution.
- It is the producer side of the ALU control interface. ALU encoding: 000 add, 001 sub, 010 and, 100 xor; any other code yields result 0 and Zero 0. Zero = (SrcA==SrcB) for every valid code.

---
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath: decodes op/funct3/funct7b5
// into datapath strobes and ALU control. Optional macro CTRL_BNE_EN enables bne.
module multicycle_ctrl #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 illegal
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;

  logic [3:0] state, next;
  logic       fn_ok, br_ok, taken, ill_dec;
  logic [2:0] alu_fn;
  logic       pc_w, mem_w, ir_w, reg_w;

  // ALU op shared by R and I forms; funct7b5 selects sub only for R-type
  always_comb begin
    alu_fn = ALU_ADD;
    fn_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b100:  alu_fn = ALU_XOR;
      default: fn_ok  = 1'b0;
    endcase
  end

  always_comb begin
    br_ok = 1'b0;
    taken = 1'b0;
    case (funct3)
      3'b000: begin br_ok = 1'b1; taken = Zero; end
`ifdef CTRL_BNE_EN
      3'b001: begin br_ok = 1'b1; taken = ~Zero; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    ill_dec = 1'b0;
    next    = FETCH;
    case (state)
      FETCH:  next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:   if (fn_ok) next = EXECR;  else ill_dec = 1'b1;
          OP_I:   if (fn_ok) next = EXECI;  else ill_dec = 1'b1;
          OP_BR:  if (br_ok) next = BRANCH; else ill_dec = 1'b1;
          OP_JAL: next = JAL;
          default: ill_dec = 1'b1;
        endcase
      end
      MEMADR:  next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: next = MEMWB;
      EXECR, EXECI, JAL: next = ALUWB;
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= next;
  end

  always_comb begin
    pc_w      = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUctrl   = ALU_ADD;
    case (state)
      FETCH:    begin ir_w = 1'b1; pc_w = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; ALUctrl = alu_fn; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUctrl = alu_fn; end
      ALUWB:    reg_w = 1'b1;
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_w = 1'b1; end
      BRANCH:   begin ALUSrcA = 2'b10; ALUctrl = ALU_SUB; pc_w = taken; end
      default:  ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Every architectural write is suppressed while reset is held
  assign PCWrite  = rst & pc_w;
  assign IRWrite  = rst & ir_w;
  assign MemWrite = rst & mem_w;
  assign RegWrite = rst & reg_w;
  assign illegal  = rst & ill_dec;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle expected output vectors.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUctrl;

  typedef struct { logic [16:0] vec; string nm; } exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUctrl,ImmSrc,RegWrite,illegal}
  function automatic logic [16:0] v(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                    input logic [2:0] alu, input logic [1:0] imm, input logic rw, ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction
  function automatic logic [16:0] f_v(input logic [1:0] imm);
    return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [16:0] d_v(input logic [1:0] imm, input logic ill);
    return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill);
  endfunction

  task automatic cyc(input logic r, input logic [31:0] ins, input logic z,
                     input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r; op = ins[6:0]; funct3 = ins[14:12]; funct7b5 = ins[30]; Zero = z;
    q.push_back('{e, nm});
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUctrl, ImmSrc, RegWrite, illegal};
      checks++;
      if (act !== e.vec) begin
        fails++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.vec);
      end
    end
  end

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] XORI = 32'h0FF34293;
  localparam logic [31:0] LW   = 32'h0000A183;
  localparam logic [31:0] SW   = 32'h0030A023;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] JALI = 32'h008000EF;
  localparam logic [31:0] ORR  = 32'h0020E1B3;
  localparam logic [31:0] LUI  = 32'h000001B7;

  initial begin
    logic [16:0] fm;
    fm = f_v(2'b00);
    fm[16] = 1'b0; fm[13] = 1'b0;  // PCWrite/IRWrite masked in reset
    // reset: state forced to FETCH, writes masked
    cyc(0, ADD, 0, fm, "reset_fetch_masked");
    // add
    cyc(1, ADD, 0, f_v(2'b00), "add_fetch");
    cyc(1, ADD, 0, d_v(2'b00, 0), "add_decode");
    cyc(1, ADD, 0, v(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0), "add_execr");
    cyc(1, ADD, 0, v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0), "add_aluwb");
    // sub
    cyc(1, SUB, 0, f_v(2'b00), "sub_fetch");
    cyc(1, SUB, 0, d_v(2'b00, 0), "sub_decode");
    cyc(1, SUB, 0, v(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0), "sub_execr");
    cyc(1, SUB, 0, v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0), "sub_aluwb");
    // xori
    cyc(1, XORI, 0, f_v(2'b00), "xori_fetch");
    cyc(1, XORI, 0, d_v(2'b00, 0), "xori_decode");
    cyc(1, XORI, 0, v(0,0,0,0,2'b00,2'b10,2'b01,3'b100,2'b00,0,0), "xori_execi");
    cyc(1, XORI, 0, v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0), "xori_aluwb");
    // lw: 5 cycles
    cyc(1, LW, 0, f_v(2'b00), "lw_fetch");
    cyc(1, LW, 0, d_v(2'b00, 0), "lw_decode");
    cyc(1, LW, 0, v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0), "lw_memadr");
    cyc(1, LW, 0, v(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0), "lw_memread");
    cyc(1, LW, 0, v(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0), "lw_memwb");
    // sw: 4 cycles, single MemWrite
    cyc(1, SW, 0, f_v(2'b01), "sw_fetch");
    cyc(1, SW, 0, d_v(2'b01, 0), "sw_decode");
    cyc(1, SW, 0, v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0), "sw_memadr");
    cyc(1, SW, 0, v(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0), "sw_memwrite");
    // beq taken / not taken
    cyc(1, BEQ, 0, f_v(2'b10), "beq1_fetch");
    cyc(1, BEQ, 0, d_v(2'b10, 0), "beq1_decode");
    cyc(1, BEQ, 1, v(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0), "beq_taken");
    cyc(1, BEQ, 0, f_v(2'b10), "beq2_fetch");
    cyc(1, BEQ, 0, d_v(2'b10, 0), "beq2_decode");
    cyc(1, BEQ, 0, v(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0), "beq_not_taken");
    // bne
    cyc(1, BNE, 0, f_v(2'b10), "bne_fetch");
`ifdef CTRL_BNE_EN
    cyc(1, BNE, 0, d_v(2'b10, 0), "bne_decode");
    cyc(1, BNE, 0, v(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0), "bne_taken");
    cyc(1, BNE, 0, f_v(2'b10), "bne2_fetch");
    cyc(1, BNE, 0, d_v(2'b10, 0), "bne2_decode");
    cyc(1, BNE, 1, v(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0), "bne_not_taken");
`else
    cyc(1, BNE, 0, d_v(2'b10, 1), "bne_illegal");
`endif
    // jal: 4 cycles
    cyc(1, JALI, 0, f_v(2'b11), "jal_fetch");
    cyc(1, JALI, 0, d_v(2'b11, 0), "jal_decode");
    cyc(1, JALI, 0, v(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0), "jal_jal");
    cyc(1, JALI, 0, v(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,0), "jal_aluwb");
    // illegal encodings: pulse in DECODE, straight back to FETCH
    cyc(1, ORR, 0, f_v(2'b00), "or_fetch");
    cyc(1, ORR, 0, d_v(2'b00, 1), "or_illegal");
    cyc(1, LUI, 0, f_v(2'b00), "lui_fetch");
    cyc(1, LUI, 0, d_v(2'b00, 1), "lui_illegal");
    // reset during lw MEMREAD aborts it
    cyc(1, LW, 0, f_v(2'b00), "rlw_fetch");
    cyc(1, LW, 0, d_v(2'b00, 0), "rlw_decode");
    cyc(1, LW, 0, v(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0), "rlw_memadr");
    cyc(0, LW, 0, v(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0), "rlw_memread_rst");
    cyc(0, LW, 0, fm, "rlw_fetch_masked");
    cyc(1, LW, 0, f_v(2'b00), "rlw_fetch_after");
    cyc(1, LW, 0, d_v(2'b00, 0), "rlw_decode_after");
    // drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
